demux1_8_16b_buf: RTL
=====================

Name: demux1_8_16b_buf

Overview:
- Registered 1-to-8 distributor for 16-bit words; the inverse of the 8:1 16-bit select path.
- One input stream carries a word plus a 3-bit destination select. The word is steered into one of eight per-channel FIFOs.
- Each channel drains independently through its own valid/ready handshake.
- Sits between a single producer (e.g. write-back/forwarding source) and up to eight consumers that may stall independently.

Parameters:
- DEPTH, 2, entries per channel FIFO. Legal values are 2 or 4.
- PW, 1, pointer width. Must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  16  word to distribute
- in_sel  input  3  destination channel, 0..7
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  selected channel can accept this cycle
- out_data  output  128  channel i head word at [16i+15:16i]
- out_valid  output  8  channel i holds at least one word
- out_ready  input  8  consumer i takes head word this cycle
- full  output  8  channel i count == DEPTH
- in_bcast  input  1  broadcast request; present only with DEMUX_BCAST_EN

Behaviour:
- Reset (rst_n low, asynchronous): all counts, read/write pointers and storage cleared.
  - out_valid = 0, full = 0, out_data = 0.
  - in_ready is combinational and reflects the empty state: 1.
- Per-channel state: storage DEPTH x 16, wr_ptr, rd_ptr (PW bits, wrap modulo DEPTH), count (0..DEPTH).
- Pop on channel i: out_valid[i] & out_ready[i]. rd_ptr[i] advances and wraps from DEPTH-1 to 0.
- out_ready[i] while out_valid[i]=0 is ignored; no state change.
- in_ready = (count[in_sel] < DEPTH) | (out_valid[in_sel] & out_ready[in_sel]).
  - Combinational path from out_ready to in_ready is permitted and required.
- Push: in_valid & in_ready.
  - Writes in_data to storage[in_sel][wr_ptr].
  - wr_ptr advances with wrap.
  - Only channel in_sel is touched.
- Count update per channel:
  - push only: +1
  - pop only: -1
  - push and pop same cycle: unchanged, including when full (pass-through at full allowed)
  - neither: unchanged
- Latency: a word pushed into an empty channel appears on out_data/out_valid the next cycle. There is no combinational bypass from in_data to out_data.
- out_data[i] always shows storage[i][rd_ptr[i]].
  - When out_valid[i]=0 it holds the last popped word, or 0 after reset. Consumers must not rely on it.
- Ordering: strictly FIFO per channel. No ordering guarantee across channels.
- in_valid=1 with in_ready=0: no state change. Producer must hold in_data/in_sel stable until accepted.
- full[i] is registered-state derived: count[i] == DEPTH.
- Reset asserted mid-transfer: all buffered words discarded. No pop or push completes in the reset cycle.

Optional Feature:
- Macro: DEMUX_BCAST_EN
- Defined:
  - Port in_bcast exists.
  - When in_valid & in_bcast, in_sel is ignored.
  - in_ready = AND over all i of (count[i] < DEPTH | (out_valid[i] & out_ready[i])).
  - On accept, in_data is pushed into all eight channels in the same cycle, each with its own wr_ptr/count update.
  - Broadcast is all-or-nothing: never a partial write.
- Not defined:
  - Port absent.
  - Only single-channel steering exists; logic identical to in_bcast=0.

Test Plan:
- Reset then push 0xBEEF to sel=5 -> next cycle out_valid=8'b0010_0000, out_data[95:80]=0xBEEF; all other channels unchanged.
- DEPTH=2: push 0x0001, 0x0002, 0x0003 to sel=3 with out_ready=0 -> in_ready=0 on the third push, full[3]=1. Set out_ready[3]=1 -> 0x0001, then 0x0002, then 0x0003 drain in order.
- Channel 3 full, in_valid=1 to sel=3 with out_ready[3]=1 the same cycle -> in_ready=1, head pops, new word enqueued, count stays 2.
- Channel 0 full, push 0x1234 to sel=6 -> accepted immediately (in_ready=1); channel 0 contents unaffected.
- Four pushes to sel=1 with DEPTH=2, interleaved pops every cycle -> pointer wrap, data order preserved.
- Assert rst_n=0 asynchronously between clock edges with two channels holding data -> out_valid=0 and out_data=0 immediately. With DEMUX_BCAST_EN: broadcast 0xA5A5 with channel 7 full -> no channel written; once channel 7 drains, all eight out_valid=1 with 0xA5A5.

Source files
------------

// File: rtl/demux1_8_16b_buf.sv
// ---------------------------------------------------------------------------
// demux1_8_16b_buf
//
// Registered 1-to-8 distributor for 16-bit words. A single producer presents
// a word plus a 3-bit destination select. The word is written into one of
// eight small per-channel FIFOs. Each channel drains independently through
// its own valid/ready handshake, so consumers can stall without affecting
// each other.
//
// Optional feature (compile-time macro DEMUX_BCAST_EN):
//   Adds input in_bcast. When in_valid & in_bcast, in_sel is ignored and the
//   word is written into all eight channels in the same cycle. A broadcast is
//   all-or-nothing: it is accepted only when every channel can take a word.
//   With the macro undefined the port does not exist and the logic behaves as
//   if in_bcast were tied to 0.
//
// Parameters:
//   DEPTH  entries per channel FIFO (2 or 4)
//   PW     pointer width, log2(DEPTH)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset; clears counts, pointers, storage
//   in_data    word to distribute
//   in_sel     destination channel 0..7
//   in_valid   in_data/in_sel valid this cycle
//   in_bcast   broadcast request (DEMUX_BCAST_EN only)
//   in_ready   destination channel(s) can accept this cycle (combinational)
//   out_data   channel i head word at [16i+15:16i]
//   out_valid  channel i holds at least one word
//   out_ready  consumer i takes its head word this cycle
//   full       channel i holds DEPTH words
// ---------------------------------------------------------------------------
module demux1_8_16b_buf #(
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  in_data,
  input  logic [2:0]   in_sel,
  input  logic         in_valid,
`ifdef DEMUX_BCAST_EN
  input  logic         in_bcast,
`endif
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [7:0]   full
);

  localparam int NCH = 8;
  // Count needs one more bit than the pointers to represent DEPTH itself.
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two (2**PW).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  // Occupancy update: a simultaneous push and pop leaves the count unchanged,
  // which is what allows pass-through while a channel is full.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic          pu,
                                             input logic          po);
    case ({pu, po})
      2'b10:   return c + CW'(1);
      2'b01:   return c - CW'(1);
      default: return c;
    endcase
  endfunction

  logic           bcast;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] room;
  logic [NCH-1:0] push;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A channel can take a word if it has a free slot, or if its consumer is
  // popping the head this very cycle. The second term makes in_ready depend
  // combinationally on out_ready.
  always_comb begin
    in_ready = room[in_sel];
    if (bcast) begin
      in_ready = &room;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    assign out_valid[g] = (cnt != '0);
    assign full[g]      = (cnt == DEPTH_CNT);
    assign pop[g]       = out_valid[g] & out_ready[g];
    assign room[g]      = (cnt < DEPTH_CNT) | pop[g];
    // in_ready already folds in every targeted channel, so a broadcast either
    // writes all eight channels or none.
    assign push[g]      = in_valid & in_ready & (bcast | (in_sel == 3'(g)));

    // Head word is read straight from storage; no bypass from in_data.
    assign out_data[16*g +: 16] = mem[rd_ptr];

    // Channel state: storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
        end
      end else begin
        // When full with a concurrent pop, wr_ptr == rd_ptr: the old head is
        // consumed this cycle and its slot is refilled at the same edge.
        if (push[g]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop[g]) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        cnt <= cnt_next(cnt, push[g], pop[g]);
      end
    end
  end

endmodule
